// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the fetch FSM state enum, reset PC, HLT opcode and the IF/ID record.
// Also provides a small helper that recognises the HLT opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [3:0]  OPC_HLT  = 4'b1111;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
  } ifid_t;

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == OPC_HLT;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding a fetched word while the decode stage is stalled.
// Latency: written on the load edge, visible next cycle; drain/clear empty it.
// Backpressure: no internal flow control; the owning FSM loads it only when empty.
// Ports: load_i/drain_i/clear_i controls, instr_i/pc_plus2_i write data,
//        full_o occupancy, dat_o stored entry (dat_o.valid mirrors full_o).
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_plus2_i,
  output logic        full_o,
  output ifid_t       dat_o
);

  ifid_t buf_q;

  // Clear (redirect) wins over load so a word fetched alongside a redirect never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (clear_i) begin
      buf_q.valid <= 1'b0;
    end else if (load_i) begin
      buf_q.instr    <= instr_i;
      buf_q.pc_plus2 <= pc_plus2_i;
      buf_q.valid    <= 1'b1;
    end else if (drain_i) begin
      buf_q.valid <= 1'b0;
    end
  end

  assign full_o = buf_q.valid;
  assign dat_o  = buf_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, IF/ID register, redirect and HLT handling.
// Latency: a word returned with imem_ready lands in IF/ID on the same edge (1 instr/cycle).
// Backpressure: stall freezes PC/IF/ID; a word arriving under stall parks in a hold buffer.
// Ports: clk/rst_n; branch_taken/branch_target redirect; stall; imem_req/imem_addr/
//        imem_ready/imem_data memory handshake; pc, ifid_* and halted status outputs.
// Optional: define FETCH_PERF_EN to add the saturating flush_cnt redirect counter port.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] flush_cnt
`endif
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  ifid_t       ifid_q, ifid_d;

  logic        buf_load, buf_drain, buf_clear, buf_full;
  ifid_t       buf_dat;

  logic [15:0] pc_plus2;
  logic [15:0] tgt;

  assign pc_plus2 = pc_q + 16'd2;           // natural 16-bit wrap FFFE -> 0000
  assign tgt      = branch_target & 16'hFFFE;

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (buf_load),
    .drain_i    (buf_drain),
    .clear_i    (buf_clear),
    .instr_i    (imem_data),
    .pc_plus2_i (pc_plus2),
    .full_o     (buf_full),
    .dat_o      (buf_dat)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      ifid_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ifid_q       <= ifid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ifid_d       = ifid_q;
    buf_load     = 1'b0;
    buf_drain    = 1'b0;
    buf_clear    = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (branch_taken) begin
          pc_d         = tgt;
          ifid_d.valid = 1'b0;
          buf_clear    = 1'b1;
          // The in-flight request cannot be withdrawn: remember its address and
          // keep presenting it until the memory answers, then throw the word away.
          if (!imem_ready) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus2;
          if (stall) begin
            buf_load = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            ifid_d.instr    = imem_data;
            ifid_d.pc_plus2 = pc_plus2;
            ifid_d.valid    = 1'b1;
            if (is_hlt(imem_data)) state_d = ST_HALT;
          end
        end else if (!stall) begin
          // Decode consumed the current entry and nothing new arrived: bubble.
          ifid_d.valid = 1'b0;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_d         = tgt;
          ifid_d.valid = 1'b0;
          buf_clear    = 1'b1;
          state_d      = ST_FETCH;
        end else if (!stall && buf_full) begin
          ifid_d    = buf_dat;
          buf_drain = 1'b1;
          state_d   = is_hlt(buf_dat.instr) ? ST_HALT : ST_FETCH;
        end
      end

      ST_DRAIN: begin
        // A further redirect only retargets; the old request is still owed a reply.
        if (branch_taken) begin
          pc_d         = tgt;
          ifid_d.valid = 1'b0;
        end
        if (imem_ready) state_d = ST_FETCH;
      end

      ST_HALT: begin
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    halted    = (state_q == ST_HALT);
  end

  assign pc            = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus2 = ifid_q.pc_plus2;
  assign ifid_valid    = ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic [15:0] flush_cnt_q;
  logic        br_acc;

  assign br_acc = branch_taken && (state_q != ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= 16'h0000;
    end else if (br_acc && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queue-based reference model checked every cycle.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] flush_cnt;
`endif

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .flush_cnt     (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: plain program-order description of the fetch rules.
  logic [15:0] m_pc, m_instr, m_pc2, m_daddr, m_cnt;
  logic        m_valid, m_halt, m_drain;
  logic [31:0] m_buf[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000; m_daddr = 16'h0000;
    m_cnt = 16'h0000; m_valid = 1'b0; m_halt = 1'b0; m_drain = 1'b0;
    m_buf.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] w;
    logic        outstanding;
    outstanding = (m_buf.size() == 0);
    if (m_halt) return;
    if (branch_taken) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (outstanding && !imem_ready) begin
        if (!m_drain) m_daddr = m_pc;
        m_drain = 1'b1;
      end else begin
        m_drain = 1'b0;
      end
      m_buf.delete();
      m_valid = 1'b0;
      m_pc = branch_target & 16'hFFFE;
    end else if (m_drain) begin
      if (imem_ready) m_drain = 1'b0;
    end else if (!outstanding) begin
      if (!stall) begin
        w = m_buf.pop_front();
        m_instr = w[31:16]; m_pc2 = w[15:0]; m_valid = 1'b1;
        m_halt = (w[31:28] == 4'hF);
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_buf.push_back({imem_data, m_pc + 16'd2});
      end else begin
        m_instr = imem_data; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
        m_halt = (imem_data[15:12] == 4'hF);
      end
      m_pc = m_pc + 16'd2;
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_all();
    logic exp_req;
    exp_req = !m_halt && (m_buf.size() == 0);
    chk1("cmp_imem_req", imem_req, exp_req);
    if (exp_req) chk("cmp_imem_addr", imem_addr, m_drain ? m_daddr : m_pc);
    chk("cmp_pc", pc, m_pc);
    chk1("cmp_ifid_valid", ifid_valid, m_valid);
    chk("cmp_ifid_instr", ifid_instr, m_instr);
    chk("cmp_ifid_pc_plus2", ifid_pc_plus2, m_pc2);
    chk1("cmp_halted", halted, m_halt);
`ifdef FETCH_PERF_EN
    chk("cmp_flush_cnt", flush_cnt, m_cnt);
`endif
  endtask

  // Apply one cycle of inputs (called #1 after a rising edge), then check.
  task automatic cyc(input logic br, input logic [15:0] tgt, input logic st,
                     input logic rdy, input logic [15:0] dat);
    branch_taken = br; branch_target = tgt; stall = st; imem_ready = rdy; imem_data = dat;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Short reset pulse inside a cycle; checks the asynchronous clear before release.
  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_pulse_pc", pc, 16'h0000);
    chk1("rst_pulse_req", imem_req, 1'b1);
    chk("rst_pulse_addr", imem_addr, 16'h0000);
    chk1("rst_pulse_halted", halted, 1'b0);
    chk1("rst_pulse_valid", ifid_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("rst_pulse_flush_cnt", flush_cnt, 16'h0000);
`endif
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] t;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0000; stall = 1'b0;
    imem_ready = 1'b0; imem_data = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    compare_all();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_addr", imem_addr, 16'h0000);
    chk1("reset_req", imem_req, 1'b1);
    chk("reset_instr", ifid_instr, 16'h0000);

    // Back-to-back single-cycle fetches
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
    chk("seq_instr0", ifid_instr, 16'h1234);
    chk("seq_pc2_0", ifid_pc_plus2, 16'h0002);
    chk("seq_addr1", imem_addr, 16'h0002);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5678);
    chk("seq_instr1", ifid_instr, 16'h5678);
    chk("seq_pc2_1", ifid_pc_plus2, 16'h0004);

    // Stall while a word returns at 0x0004
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 16'hA001);
    chk1("hold_req", imem_req, 1'b0);
    chk("hold_pc", pc, 16'h0006);
    chk("hold_instr_frozen", ifid_instr, 16'h5678);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk1("hold_req_3", imem_req, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("hold_release_instr", ifid_instr, 16'hA001);
    chk("hold_release_pc2", ifid_pc_plus2, 16'h0006);
    chk1("hold_release_valid", ifid_valid, 1'b1);

    // Redirect during a slow (3-cycle) request
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
    chk("drain_addr_old", imem_addr, 16'h0006);
    chk("drain_pc", pc, 16'h0040);
    chk1("drain_valid", ifid_valid, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    chk("drain_next_addr", imem_addr, 16'h0040);
    chk1("drain_word_dropped", ifid_valid, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222);
    chk("drain_after_instr", ifid_instr, 16'h2222);
    chk("drain_after_pc2", ifid_pc_plus2, 16'h0042);

    // Redirect while holding a buffered word
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333);
    cyc(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000);
    chk("holdbr_addr", imem_addr, 16'h0100);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h4444);
    chk("holdbr_instr", ifid_instr, 16'h4444);

    // PC wrap
    cyc(1'b1, 16'hFFFE, 1'b0, 1'b1, 16'h5555);
    chk("wrap_pc_tgt", pc, 16'hFFFE);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h6666);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pc2", ifid_pc_plus2, 16'h0000);

    // Target bit 0 forced low; HLT coincident with redirect is dropped; then real HLT
    cyc(1'b1, 16'h0011, 1'b0, 1'b1, 16'h7777);
    chk("tgt_bit0", pc, 16'h0010);
    cyc(1'b1, 16'h0010, 1'b0, 1'b1, 16'hF000);
    chk1("hlt_coincident", halted, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'hF000);
    chk1("hlt_halted", halted, 1'b1);
    chk1("hlt_req", imem_req, 1'b0);
    chk("hlt_pc", pc, 16'h0012);
    for (int i = 0; i < 20; i++) begin
      cyc((i % 2) == 1, 16'h0200, (i % 3) == 0, 1'b1, 16'h1000);
    end
    chk("hlt_pc_after", pc, 16'h0012);
    chk("hlt_instr_kept", ifid_instr, 16'hF000);
    chk1("hlt_still", halted, 1'b1);

    // Only reset leaves HALT
    reset_pulse();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    // Five accepted redirects, then a reset in the middle of a drain
    for (int k = 1; k <= 5; k++) begin
      t = 16'(k * 32);
      cyc(1'b1, t, 1'b0, 1'b1, 16'h0000);
    end
`ifdef FETCH_PERF_EN
    chk("perf_five", flush_cnt, 16'h0005);
`endif
    cyc(1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000);
    chk("drain2_addr", imem_addr, 16'h00A0);
`ifdef FETCH_PERF_EN
    chk("perf_six", flush_cnt, 16'h0006);
`endif
    reset_pulse();
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1357);
    chk("post_rst_instr", ifid_instr, 16'h1357);
    chk("post_rst_pc2", ifid_pc_plus2, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
